// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin owner of the shared magnitude comparator.
// Grants one requester and registers its operands onto the comparator
// inputs. After CMP_LAT settle cycles it captures the three flags and
// returns them tagged with the owner's index. It also flags a result
// whose e/g/l set is not exactly one-hot.
//
// Handshake: req[i] is a level request. gnt[i] is a one-cycle acknowledge.
// Operands of requester i are taken at the edge that raises gnt[i], so the
// requester may drop req and change its operands from the gnt cycle on.
// done is a one-cycle valid with no backpressure. res_* hold until the
// next capture. req is ignored while busy.
module cmp_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 16,
  parameter int CMP_LAT = 1,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic [WIDTH-1:0]       cmp_a,
  output logic [WIDTH-1:0]       cmp_b,
  input  logic                   cmp_e,
  input  logic                   cmp_g,
  input  logic                   cmp_l,
  output logic                   done,
  output logic [ID_W-1:0]        done_id,
  output logic                   res_e,
  output logic                   res_g,
  output logic                   res_l,
  output logic                   err
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr;      // last granted requester
  logic [ID_W-1:0] win;      // winner of the current search
  logic [ID_W-1:0] idx;
  logic [N_REQ-1:0] win_oh;
  logic            found;
  logic [2:0]      cnt;      // settle cycles remaining
  logic            load;
  logic            capture;
  logic            flags_onehot;

  // Round-robin search upward from ptr+1, wrapping at N_REQ-1.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (idx == ID_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // One-hot form of the winner, driven onto gnt at the grant edge.
  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  // Exactly one of equal/greater/less is expected from a healthy comparator.
  always_comb begin
    case ({cmp_e, cmp_g, cmp_l})
      3'b100, 3'b010, 3'b001: flags_onehot = 1'b1;
      default:                flags_onehot = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and strobes: grant from IDLE, capture on the last settle cycle.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          load      = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 3'd1) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant/launch, settle counting and result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt     <= '0;
      busy    <= 1'b0;
      cmp_a   <= '0;
      cmp_b   <= '0;
      ptr     <= ID_W'(N_REQ - 1);
      cnt     <= '0;
      done    <= 1'b0;
      done_id <= '0;
      res_e   <= 1'b0;
      res_g   <= 1'b0;
      res_l   <= 1'b0;
      err     <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      err  <= 1'b0;
      if (load) begin
        gnt   <= win_oh;
        busy  <= 1'b1;
        cmp_a <= a_in[int'(win)*WIDTH +: WIDTH];
        cmp_b <= b_in[int'(win)*WIDTH +: WIDTH];
        ptr   <= win;
        cnt   <= 3'(CMP_LAT);
      end
      if (state == WAIT) cnt <= cnt - 1'b1;
      if (capture) begin
        res_e   <= cmp_e;
        res_g   <= cmp_g;
        res_l   <= cmp_l;
        done    <= 1'b1;
        done_id <= ptr;
        err     <= !flags_onehot;
        busy    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: two arbiters (CMP_LAT=1 and CMP_LAT=3), each driving its
// own behavioural comparator. Directed tables and sequences, then a random
// run scored against a round-robin reference model.
module tb_cmp_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n1, rst_n3;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in, b_in;
  logic           force_eg;

  logic [N-1:0] gnt1, gnt3;
  logic         busy1, busy3, done1, done3, err1, err3;
  logic [W-1:0] ca1, cb1, ca3, cb3;
  logic         e1, g1, l1, e3, g3, l3;
  logic [1:0]   id1, id3;
  logic         re1, rg1, rl1, re3, rg3, rl3;

  // Behavioural comparators; force_eg injects a double-flag fault.
  assign e1 = (ca1 == cb1) | force_eg;
  assign g1 = (ca1 >  cb1) | force_eg;
  assign l1 = (ca1 <  cb1);
  assign e3 = (ca3 == cb3);
  assign g3 = (ca3 >  cb3);
  assign l3 = (ca3 <  cb3);

  cmp_arbiter #(.N_REQ(N), .WIDTH(W), .CMP_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n1), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt1), .busy(busy1), .cmp_a(ca1), .cmp_b(cb1),
    .cmp_e(e1), .cmp_g(g1), .cmp_l(l1),
    .done(done1), .done_id(id1), .res_e(re1), .res_g(rg1), .res_l(rl1),
    .err(err1)
  );

  cmp_arbiter #(.N_REQ(N), .WIDTH(W), .CMP_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n3), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt3), .busy(busy3), .cmp_a(ca3), .cmp_b(cb3),
    .cmp_e(e3), .cmp_g(g3), .cmp_l(l3),
    .done(done3), .done_id(id3), .res_e(re3), .res_g(rg3), .res_l(rl3),
    .err(err3)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [4:0] exp_q[$];   // {done_id, e, g, l}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks / model ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Unsigned magnitude compare from plain arithmetic: {eq, gt, lt}.
  function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b);
    return {a == b, a > b, a < b};
  endfunction

  // First set request strictly after p, going round the ring.
  function automatic int pick(input int p, input logic [N-1:0] r);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (p + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk_reset1(input string tag);
    chk({tag, "_gnt"},  gnt1, 0);
    chk({tag, "_busy"}, busy1, 0);
    chk({tag, "_done"}, done1, 0);
    chk({tag, "_id"},   id1, 0);
    chk({tag, "_res"},  {re1, rg1, rl1}, 0);
    chk({tag, "_err"},  err1, 0);
    chk({tag, "_ops"},  {ca1, cb1}, 0);
  endtask

  task automatic chk_reset3(input string tag);
    chk({tag, "_gnt"},  gnt3, 0);
    chk({tag, "_busy"}, busy3, 0);
    chk({tag, "_done"}, done3, 0);
    chk({tag, "_id"},   id3, 0);
    chk({tag, "_res"},  {re3, rg3, rl3}, 0);
    chk({tag, "_err"},  err3, 0);
    chk({tag, "_ops"},  {ca3, cb3}, 0);
  endtask

  typedef struct {
    int         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0] egl;
  } vec_t;

  vec_t vt[6];

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    int mptr, w, r;
    logic [W-1:0] aw, bw;
    logic [4:0] ex;

    vt[0] = '{2, 16'h1234, 16'h1233, 3'b010};
    vt[1] = '{0, 16'hFFFF, 16'hFFFF, 3'b100};
    vt[2] = '{1, 16'h8000, 16'h7FFF, 3'b010};
    vt[3] = '{3, 16'h0000, 16'h0001, 3'b001};
    vt[4] = '{2, 16'h0001, 16'h8000, 3'b001};
    vt[5] = '{0, 16'h0000, 16'h0000, 3'b100};

    rst_n1 = 1'b0; rst_n3 = 1'b0; req = '0; a_in = '0; b_in = '0; force_eg = 1'b0;
    repeat (3) tick();
    chk_reset1("rst1");

    // Fairness: all requesting straight out of reset.
    for (int i = 0; i < N; i++) set_ops(i, 16'h1000 + W'(i), 16'h1000);
    req = 4'b1111;
    tick();
    rst_n1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("fair_gnt%0d", k), gnt1, oh(k % N));
      chk($sformatf("fair_opa%0d", k), ca1, 16'h1000 + (k % N));
      chk($sformatf("fair_busy%0d", k), busy1, 1);
      if (k == 4) req = '0;
      tick();
      chk($sformatf("fair_done%0d", k), {done1, gnt1}, {1'b1, 4'b0000});
      chk($sformatf("fair_id%0d", k), id1, k % N);
    end

    // Double-flag fault during WAIT.
    req = 4'b0010;
    set_ops(1, 16'h0005, 16'h0003);
    tick();
    chk("fault_gnt", gnt1, 4'b0010);
    req = '0;
    force_eg = 1'b1;
    tick();
    force_eg = 1'b0;
    chk("fault_done", done1, 1);
    chk("fault_err", err1, 1);
    chk("fault_res", {re1, rg1, rl1}, 3'b110);

    // Table of single requests (first one also shows err back to 0).
    for (int i = 0; i < 6; i++) begin
      req = oh(vt[i].id);
      set_ops(vt[i].id, vt[i].a, vt[i].b);
      tick();
      chk($sformatf("tab%0d_gnt", i), gnt1, oh(vt[i].id));
      chk($sformatf("tab%0d_busy", i), busy1, 1);
      chk($sformatf("tab%0d_ops", i), {ca1, cb1}, {vt[i].a, vt[i].b});
      chk($sformatf("tab%0d_early", i), done1, 0);
      req = '0;
      tick();
      chk($sformatf("tab%0d_done", i), done1, 1);
      chk($sformatf("tab%0d_id", i), id1, vt[i].id);
      chk($sformatf("tab%0d_res", i), {re1, rg1, rl1}, vt[i].egl);
      chk($sformatf("tab%0d_err", i), err1, 0);
      chk($sformatf("tab%0d_idle", i), {busy1, gnt1}, 0);
    end
    mptr = vt[5].id;

    // Random run against the round-robin model.
    for (int it = 0; it < 80; it++) begin
      r   = $urandom_range(0, 15);
      req = N'(r);
      for (int i = 0; i < N; i++) begin
        aw = W'($urandom_range(0, 65535));
        bw = ($urandom_range(0, 3) == 0) ? aw : W'($urandom_range(0, 65535));
        set_ops(i, aw, bw);
      end
      tick();
      if (r == 0) begin
        chk($sformatf("rnd%0d_quiet", it), {gnt1, busy1, done1}, 0);
      end else begin
        w  = pick(mptr, N'(r));
        aw = a_in[w*W +: W];
        bw = b_in[w*W +: W];
        chk($sformatf("rnd%0d_gnt", it), gnt1, oh(w));
        chk($sformatf("rnd%0d_ops", it), {ca1, cb1}, {aw, bw});
        exp_q.push_back({2'(w), ref_cmp(aw, bw)});
        mptr = w;
        // Junk during WAIT must be ignored.
        req  = N'($urandom_range(0, 15));
        a_in = {$urandom, $urandom};
        b_in = {$urandom, $urandom};
        tick();
        chk($sformatf("rnd%0d_done", it), {done1, gnt1, busy1}, {1'b1, 4'b0000, 1'b0});
        ex = exp_q.pop_front();
        chk($sformatf("rnd%0d_res", it), {id1, re1, rg1, rl1}, ex);
        chk($sformatf("rnd%0d_err", it), err1, 0);
      end
    end
    chk("rnd_q_empty", exp_q.size(), 0);

    // ---- CMP_LAT=3 instance ----
    req = '0;
    rst_n1 = 1'b0;
    tick();
    chk_reset3("rst3");
    rst_n3 = 1'b1;
    tick();

    // Latency: req[3] at T, req[0] raised at T+2 while busy.
    req = 4'b1000;
    set_ops(3, 16'h00FF, 16'h0F00);
    tick();                                        // T+1
    chk("lat_gnt", gnt3, 4'b1000);
    chk("lat_busy1", busy3, 1);
    chk("lat_opa", ca3, 16'h00FF);
    req = '0;
    tick();                                        // T+2
    chk("lat_t2", {gnt3, busy3, done3}, {4'b0000, 1'b1, 1'b0});
    req = 4'b0001;
    set_ops(0, 16'hABCD, 16'hABCD);
    tick();                                        // T+3
    chk("lat_t3", {gnt3, busy3, done3}, {4'b0000, 1'b1, 1'b0});
    tick();                                        // T+4
    chk("lat_t4", {gnt3, busy3, done3}, {4'b0000, 1'b0, 1'b1});
    chk("lat_id3", id3, 3);
    chk("lat_res3", {re3, rg3, rl3}, 3'b001);
    tick();                                        // T+5
    chk("lat_gnt0", gnt3, 4'b0001);
    chk("lat_opa0", ca3, 16'hABCD);
    req = '0;
    tick();
    tick();
    chk("lat_nodone", done3, 0);
    tick();
    chk("lat_done0", {done3, id3, re3, rg3, rl3, err3}, {1'b1, 2'd0, 3'b100, 1'b0});

    // Reset in the second WAIT cycle aborts the comparison.
    tick();
    req = 4'b0010;
    set_ops(1, 16'h0002, 16'h0001);
    tick();                                        // T+1
    chk("abort_gnt", gnt3, 4'b0010);
    req = '0;
    tick();                                        // T+2
    rst_n3 = 1'b0;
    tick();                                        // T+3
    chk_reset3("abort");
    tick();                                        // T+4
    chk("abort_nodone", done3, 0);
    rst_n3 = 1'b1;
    req = 4'b0011;
    tick();
    chk("abort_regrant", gnt3, 4'b0001);
    req = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("abort_wait%0d", k), done3, (k == 2));
    end
    chk("abort_id", id3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
